hs_sync_tx: RTL and testbench

//  Source-domain (sending) end of a 4-phase req/ack level handshake for moving a

---
 rtl/hs_sync_tx_if.sv | 27 ++
 rtl/hs_sync_tx.sv | 96 +++++++++
 tb/tb_hs_sync_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_sync_tx_if.sv
// Bundle of the source-side load port and the req/ack/data wires that cross to the
// destination clock domain.
`timescale 1ns/1ps
interface hs_sync_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  req_lvl;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  ack_lvl;
    logic                  done_pulse;
    logic                  drop_err;

    // Environment side: producer of words plus the returning ack from the far domain
    modport master (
        output src_valid, src_data, ack_lvl,
        input  src_ready, req_lvl, tx_data, done_pulse, drop_err
    );

    // Sender block side
    modport slave (
        input  src_valid, src_data, ack_lvl,
        output src_ready, req_lvl, tx_data, done_pulse, drop_err
    );
endinterface

// File: rtl/hs_sync_tx.sv
// Sending end of a 4-phase level req/ack handshake: holds a word on tx_data, raises
// req_lvl, synchronizes the returning ack and reports completion / dropped loads.
`timescale 1ns/1ps
module hs_sync_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_STAGES = 2
) (
    input logic         CLK,
    input logic         RST,
    hs_sync_tx_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_REL  = 2'b10;

    logic [1:0]            state_q,      state_d;
    logic [NUM_STAGES-1:0] sync_q,       sync_d;
    logic                  src_ready_q,  src_ready_d;
    logic                  req_lvl_q,    req_lvl_d;
    logic [DATA_WIDTH-1:0] tx_data_q,    tx_data_d;
    logic                  done_pulse_q, done_pulse_d;
    logic                  drop_err_q,   drop_err_d;
    logic                  ack_s_c;

    assign ack_s_c = sync_q[NUM_STAGES-1];

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[NUM_STAGES-2:0], bus.ack_lvl};
        req_lvl_d    = req_lvl_q;
        tx_data_d    = tx_data_q;
        done_pulse_d = 1'b0;
        drop_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ack_s while idle is a far-side protocol violation and is ignored
                if (bus.src_valid) begin
                    tx_data_d = bus.src_data;
                    req_lvl_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                drop_err_d = bus.src_valid;
                if (ack_s_c) begin
                    req_lvl_d = 1'b0;
                    state_d   = ST_REL;
                end
            end
            ST_REL: begin
                drop_err_d = bus.src_valid;
                if (!ack_s_c) begin
                    done_pulse_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                drop_err_d = bus.src_valid;
                req_lvl_d  = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        src_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            src_ready_q  <= 1'b1;
            req_lvl_q    <= 1'b0;
            tx_data_q    <= '0;
            done_pulse_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            src_ready_q  <= src_ready_d;
            req_lvl_q    <= req_lvl_d;
            tx_data_q    <= tx_data_d;
            done_pulse_q <= done_pulse_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign bus.src_ready  = src_ready_q;
    assign bus.req_lvl    = req_lvl_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_hs_sync_tx.sv
// Bench for hs_sync_tx: protocol-level model compared every cycle, directed
// scenarios with literal expectations, and a randomized far-side receiver.
`timescale 1ns/1ps
module tb_hs_sync_tx;
    localparam int unsigned DW = 8;
    localparam int unsigned NS = 2;

    logic    CLK  = 1'b0;
    logic    DCLK = 1'b0;
    logic    RST  = 1'b0;
    realtime dhalf = 5.0;

    always #5 CLK = ~CLK;
    always #(dhalf) DCLK = ~DCLK;

    hs_sync_tx_if #(.DATA_WIDTH(DW)) bus ();
    hs_sync_tx #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ack source select: 0 manual, 1 req looped back after 3 CLK, 2 far-domain receiver
    int          ack_mode = 0;
    logic        ack_man  = 1'b0;
    logic [2:0]  lb_q;
    logic        d_ack;
    assign bus.ack_lvl = (ack_mode == 0) ? ack_man : (ack_mode == 1) ? lb_q[2] : d_ack;

    always @(posedge CLK or negedge RST) begin
        if (!RST) lb_q <= '0;
        else      lb_q <= {lb_q[1:0], bus.req_lvl};
    end

    // Far-side receiver: sync req, capture word, answer after a random delay each phase
    logic          d_r1, d_r2;
    int            d_st, d_cnt;
    logic [DW-1:0] rx_q[$];
    always @(posedge DCLK or negedge RST) begin
        if (!RST) begin
            d_r1 <= 1'b0; d_r2 <= 1'b0; d_st <= 0; d_cnt <= 0; d_ack <= 1'b0;
        end else begin
            d_r1 <= bus.req_lvl;
            d_r2 <= d_r1;
            case (d_st)
                0: if (d_r2) begin
                       rx_q.push_back(bus.tx_data);
                       d_cnt <= int'($urandom_range(7, 0));
                       d_st  <= 1;
                   end
                1: if (d_cnt == 0) begin d_ack <= 1'b1; d_st <= 2; end
                   else d_cnt <= d_cnt - 1;
                2: if (!d_r2) begin
                       d_cnt <= int'($urandom_range(7, 0));
                       d_st  <= 3;
                   end
                default: if (d_cnt == 0) begin d_ack <= 1'b0; d_st <= 0; end
                         else d_cnt <= d_cnt - 1;
            endcase
        end
    end

    // Protocol model: a word is outstanding from accept until the ack has been seen
    // high and then low again; ack is seen NS source clocks after it arrives.
    logic [NS-1:0] m_sync;
    logic          m_busy, m_rel;
    logic          e_ready, e_req, e_done, e_drop;
    logic [DW-1:0] e_data;
    logic [DW-1:0] acc_q[$];
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_sync <= '0; m_busy <= 1'b0; m_rel <= 1'b0;
            e_ready <= 1'b1; e_req <= 1'b0; e_done <= 1'b0; e_drop <= 1'b0; e_data <= '0;
        end else begin
            m_sync <= {m_sync[NS-2:0], bus.ack_lvl};
            e_done <= 1'b0;
            e_drop <= 1'b0;
            if (!m_busy) begin
                if (bus.src_valid) begin
                    m_busy <= 1'b1; m_rel <= 1'b0;
                    e_data <= bus.src_data; e_req <= 1'b1; e_ready <= 1'b0;
                    acc_q.push_back(bus.src_data);
                end
            end else begin
                e_drop <= bus.src_valid;
                if (!m_rel && m_sync[NS-1]) begin
                    m_rel <= 1'b1; e_req <= 1'b0;
                end else if (m_rel && !m_sync[NS-1]) begin
                    m_busy <= 1'b0; e_done <= 1'b1; e_ready <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison plus held-bus stability
    logic          prev_hold = 1'b0;
    logic          prev_rst  = 1'b0;
    logic [DW-1:0] prev_tx   = '0;
    always @(negedge CLK) begin
        check("src_ready",  32'(bus.src_ready),  32'(e_ready));
        check("req_lvl",    32'(bus.req_lvl),    32'(e_req));
        check("tx_data",    32'(bus.tx_data),    32'(e_data));
        check("done_pulse", 32'(bus.done_pulse), 32'(e_done));
        check("drop_err",   32'(bus.drop_err),   32'(e_drop));
        if (RST && prev_rst && prev_hold)
            check("tx_stable", 32'(bus.tx_data), 32'(prev_tx));
        prev_hold <= bus.req_lvl | m_sync[NS-1];
        prev_tx   <= bus.tx_data;
        prev_rst  <= RST;
    end

    task automatic send(input logic [DW-1:0] w);
        bus.src_valid = 1'b1;
        bus.src_data  = w;
        @(negedge CLK);
        bus.src_valid = 1'b0;
    endtask

    task automatic window(input int n, output int dones, output logic rdy_ok, output logic req_ok);
        dones = 0; rdy_ok = 1'b1; req_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (bus.done_pulse) begin
                dones++;
                rdy_ok &= bus.src_ready;
                req_ok &= ~bus.req_lvl;
            end
        end
    endtask

    int   dones;
    logic rdy_ok, req_ok, found;
    int   n;

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        ack_man       = 1'b1;

        // Reset values with ack held high
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(bus.src_ready), 32'd1);
        check("rst_req",   32'(bus.req_lvl),   32'd0);
        check("rst_tx",    32'(bus.tx_data),   32'd0);
        check("rst_done",  32'(bus.done_pulse),32'd0);
        check("rst_drop",  32'(bus.drop_err),  32'd0);
        #2 RST = 1'b1;
        repeat (6) @(negedge CLK);
        check("ackidle_ready", 32'(bus.src_ready), 32'd1);
        check("ackidle_req",   32'(bus.req_lvl),   32'd0);
        ack_man = 1'b0;
        repeat (4) @(negedge CLK);

        // Single transfer with loopback ack
        ack_mode = 1;
        send(8'hA5);
        check("t2_tx",  32'(bus.tx_data), 32'hA5);
        check("t2_req", 32'(bus.req_lvl), 32'd1);
        window(40, dones, rdy_ok, req_ok);
        check("t2_dones",      32'(dones),  32'd1);
        check("t2_ready_done", 32'(rdy_ok), 32'd1);
        check("t2_req_done",   32'(req_ok), 32'd1);

        // Load while busy is dropped
        send(8'hA5);
        bus.src_valid = 1'b1;
        bus.src_data  = 8'h3C;
        @(negedge CLK);
        bus.src_valid = 1'b0;
        check("t3_drop", 32'(bus.drop_err), 32'd1);
        check("t3_tx",   32'(bus.tx_data),  32'hA5);
        check("t3_req",  32'(bus.req_lvl),  32'd1);
        @(negedge CLK);
        check("t3_drop_off", 32'(bus.drop_err), 32'd0);
        window(40, dones, rdy_ok, req_ok);
        check("t3_dones", 32'(dones), 32'd1);

        // Back-to-back: load in the done_pulse cycle
        send(8'h22);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            found = bus.done_pulse;
        end
        check("t4_done_seen", 32'(found), 32'd1);
        send(8'h11);
        check("t4_req",  32'(bus.req_lvl),  32'd1);
        check("t4_tx",   32'(bus.tx_data),  32'h11);
        check("t4_drop", 32'(bus.drop_err), 32'd0);
        window(40, dones, rdy_ok, req_ok);
        check("t4_dones", 32'(dones), 32'd1);

        // Reset in REQ
        send(8'h44);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1 check("t5_req_async_req", 32'(bus.req_lvl), 32'd0);
        @(negedge CLK);
        check("t5_ready_req", 32'(bus.src_ready), 32'd1);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset in REL
        send(8'h55);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            found = ~bus.req_lvl;
        end
        check("t5_rel_reached", 32'(found && m_busy), 32'd1);
        #2 RST = 1'b0;
        #1 check("t5_req_async_rel", 32'(bus.req_lvl),   32'd0);
        check("t5_ready_rel",        32'(bus.src_ready), 32'd1);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        send(8'hFF);
        check("t5_tx",  32'(bus.tx_data), 32'hFF);
        check("t5_req", 32'(bus.req_lvl), 32'd1);
        window(40, dones, rdy_ok, req_ok);
        check("t5_dones", 32'(dones), 32'd1);

        // Random stress against the far-side receiver at three clock ratios
        ack_mode = 2;
        repeat (40) @(negedge CLK);
        for (int r = 0; r < 3; r++) begin
            int target;
            dhalf  = (r == 0) ? 5.0 : (r == 1) ? 15.0 : 1.667;
            target = (r == 0) ? 334 : 333;
            repeat (10) @(negedge CLK);
            acc_q.delete();
            rx_q.delete();
            n = 0;
            while (acc_q.size() < target && n < 30000) begin
                @(negedge CLK);
                n++;
                if (acc_q.size() + (bus.src_valid ? 1 : 0) >= target && !bus.src_ready)
                    bus.src_valid = 1'b0;
                else begin
                    bus.src_valid = ($urandom_range(3, 0) == 0);
                    bus.src_data  = DW'($urandom);
                end
            end
            bus.src_valid = 1'b0;
            n = 0;
            while ((m_busy || d_st != 0 || bus.ack_lvl) && n < 1000) begin
                @(negedge CLK);
                n++;
            end
            check("sb_idle",  32'(m_busy || d_st != 0), 32'd0);
            check("sb_count", 32'(rx_q.size()),         32'(acc_q.size()));
            for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++)
                check("sb_word", 32'(rx_q[i]), 32'(acc_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
